memory_interface: RTL and testbench

//  Multi-cycle load/store unit sitting directly upstream of the mainbus memory leg.
//  - Takes address and store data from the mainbus.
//  - Drives a req/ack external memory port.
//  - Returns lane-extracted, sign/zero-extended load data on rdata, which feeds

---
 rtl/memory_interface.sv | 100 ++++++++++
 tb/tb_memory_interface.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/memory_interface.sv
// memory_interface: multi-cycle RV32I load/store unit driving a req/ack memory port.
// Define MEM_TIMEOUT_EN to abort requests left unacknowledged for TIMEOUT_CYCLES cycles.
module memory_interface #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;
  state_e state_q, state_d;
  logic        we_q, err_q, err_d, ok, tmo;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, rdata_q, rdata_d, sh, ld, be_wd;
  logic [3:0]  be;
  assign ok = (write ? funct3 inside {3'b000, 3'b001, 3'b010}
                     : funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
            && (funct3[1:0] == 2'b01 ? !addr[0] :
                funct3[1:0] == 2'b10 ? addr[1:0] == 2'b00 : 1'b1);
  assign sh = mem_rdata >> {addr_q[1:0], 3'b000};
  assign ld = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & sh[7]}}, sh[7:0]} :
              f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & sh[15]}}, sh[15:0]} : mem_rdata;
  assign be = f3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0] :
              f3_q[1:0] == 2'b01 ? 4'b0011 << addr_q[1:0] : 4'b1111;
  assign be_wd = f3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}} :
                 f3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  // Held at zero outside REQ, so it restarts on every entry into REQ.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= (state_q == REQ) ? cnt_q + 1'b1 : '0;
  assign tmo = (state_q == REQ) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    if (state_q == IDLE && start) begin
      state_d = ok ? REQ : DONE;
      err_d   = !ok;
    end else if (state_q == REQ && mem_ack) begin
      state_d = DONE;
      err_d   = 1'b0;
      rdata_d = we_q ? rdata_q : ld;
    end else if (tmo) begin
      state_d = DONE;
      err_d   = 1'b1;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (state_q == IDLE && start) begin
        we_q    <= write;
        f3_q    <= funct3;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
    end
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign err       = done && err_q;
  assign rdata     = rdata_q;
  assign mem_req   = state_q == REQ;
  assign mem_we    = mem_req && we_q;
  assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : '0;
  assign mem_be    = mem_req ? be : '0;
  assign mem_wdata = mem_req ? be_wd : '0;
endmodule

// File: tb/tb_memory_interface.sv
// tb_memory_interface: scoreboard bench; expected memory requests and completions are
// queued by the stimulus and popped by a monitor sampling on the falling edge.
module tb_memory_interface;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, write = 1'b0, mem_ack = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0, wdata = '0, mem_rdata = '0;
  logic        busy, done, err, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  int checks = 0, failures = 0, req_cyc = 0, done_cnt = 0;
  logic [68:0] req_q[$];
  logic [32:0] done_q[$];

  memory_interface #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .write(write), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    logic [68:0] r;
    logic [32:0] d;
    if (mem_req) req_cyc++;
    if (mem_req && mem_ack) begin
      if (req_q.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
      else begin
        r = req_q.pop_front();
        chk("mem_we", {31'd0, mem_we}, {31'd0, r[68]});
        chk("mem_addr", mem_addr, r[67:36]);
        chk("mem_be", {28'd0, mem_be}, {28'd0, r[35:32]});
        chk("mem_wdata", mem_wdata, r[31:0]);
      end
    end
    if (done) begin
      done_cnt++;
      if (done_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        d = done_q.pop_front();
        chk("err", {31'd0, err}, {31'd0, d[32]});
        chk("rdata", rdata, d[31:0]);
      end
    end
  end

  // dly < 0: access is expected to be rejected without a memory request
  task automatic acc(input logic w, input logic [2:0] f, input logic [31:0] a, wd, rd,
                     input int dly, input logic pulse);
    @(posedge clk); #1;
    start = 1'b1; write = w; funct3 = f; addr = a; wdata = wd; mem_rdata = rd;
    @(posedge clk); #1;
    start = 1'b0;
    if (dly < 0) begin
      chk("err_no_req", {31'd0, mem_req}, 32'd0);
      chk("err_done_next", {31'd0, done}, 32'd1);
    end else begin
      for (int i = 0; i < dly; i++) begin
        if (pulse && i == 1) begin start = 1'b1; write = 1'b1; funct3 = 3'b010; end
        @(posedge clk); #1;
        start = 1'b0;
      end
      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      chk("done_latency", {31'd0, done}, 32'd1);
    end
    @(posedge clk); #1;
    chk("idle_after", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int rc, dc;
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_be", {28'd0, mem_be}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    req_q.push_back({1'b0, 32'h100, 4'hF, 32'h0}); done_q.push_back({1'b0, 32'hDEADBEEF});
    acc(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0);
    req_q.push_back({1'b0, 32'h100, 4'h8, 32'h0}); done_q.push_back({1'b0, 32'hFFFFFF80});
    acc(1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 1, 1'b0);
    req_q.push_back({1'b0, 32'h100, 4'h8, 32'h0}); done_q.push_back({1'b0, 32'h00000080});
    acc(1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 0, 1'b0);
    req_q.push_back({1'b1, 32'h200, 4'hC, 32'hABCDABCD}); done_q.push_back({1'b0, 32'h00000080});
    acc(1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 0, 1'b0);
    done_q.push_back({1'b1, 32'h00000080});
    acc(1'b0, 3'b010, 32'h1002, 32'h0, 32'h0, -1, 1'b0);
    done_q.push_back({1'b1, 32'h00000080});
    acc(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, -1, 1'b0);
    done_q.push_back({1'b1, 32'h00000080});
    acc(1'b1, 3'b100, 32'h0, 32'h0, 32'h0, -1, 1'b0);
    done_q.push_back({1'b1, 32'h00000080});
    acc(1'b0, 3'b001, 32'h101, 32'h0, 32'h0, -1, 1'b0);
    req_q.push_back({1'b0, 32'h100, 4'h3, 32'h0}); done_q.push_back({1'b0, 32'hFFFF8001});
    acc(1'b0, 3'b001, 32'h100, 32'h0, 32'h12348001, 0, 1'b0);
    req_q.push_back({1'b1, 32'h100, 4'h2, 32'h5A5A5A5A}); done_q.push_back({1'b0, 32'hFFFF8001});
    acc(1'b1, 3'b000, 32'h101, 32'h0000005A, 32'h0, 0, 1'b0);
    req_q.push_back({1'b1, 32'h300, 4'hF, 32'h12345678}); done_q.push_back({1'b0, 32'hFFFF8001});
    acc(1'b1, 3'b010, 32'h300, 32'h12345678, 32'h0, 0, 1'b0);
    rc = req_cyc; dc = done_cnt;
    req_q.push_back({1'b0, 32'h100, 4'hC, 32'h0}); done_q.push_back({1'b0, 32'h0000CAFE});
    acc(1'b0, 3'b101, 32'h102, 32'h0, 32'hCAFE1234, 3, 1'b1);
    chk("delayed_req_cycles", req_cyc - rc, 32'd4);
    chk("delayed_done_pulses", done_cnt - dc, 32'd1);
`ifdef MEM_TIMEOUT_EN
    rc = req_cyc; dc = done_cnt;
    done_q.push_back({1'b1, 32'h0000CAFE});
    @(posedge clk); #1;
    start = 1'b1; write = 1'b0; funct3 = 3'b010; addr = 32'h400;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("tmo_req_cycles", req_cyc - rc, 32'd4);
    chk("tmo_done_pulses", done_cnt - dc, 32'd1);
`endif
    @(posedge clk); #1;
    start = 1'b1; write = 1'b0; funct3 = 3'b010; addr = 32'h500;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", {31'd0, mem_req}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("req_q_empty", req_q.size(), 32'd0);
    chk("done_q_empty", done_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
